// File: rtl/reg_file_bank.sv
// reg_file_bank: architectural integer register file x0..x31 with a post-reset
// clearing sequencer, optional same-cycle write-to-read bypass, and a debug read.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   reg_writedata_w          write data from the writeback stage
//   reg_write_addr_w         destination register index
//   reg_write_en_w           write strobe
//   rs1_addr_d, rs2_addr_d   decode source indices
//   rs1_data_d, rs2_data_d   decode source operands (combinational, bypassable)
//   dbg_addr, dbg_data       debug/trace read (combinational, never bypassed)
//   rf_ready                 high once the clearing sequence has finished
module reg_file_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          BYPASS_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] reg_writedata_w,
    input  logic [4:0]            reg_write_addr_w,
    input  logic                  reg_write_en_w,
    input  logic [4:0]            rs1_addr_d,
    input  logic [4:0]            rs2_addr_d,
    output logic [DATA_WIDTH-1:0] rs1_data_d,
    output logic [DATA_WIDTH-1:0] rs2_data_d,
    input  logic [4:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  rf_ready
);

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned LAST_IX = 31;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   next_idx;

    logic                ready_c;
    logic                clr_we_c;
    logic                wr_we_c;

    // x0 is hardwired to zero and has no storage.
    logic [DATA_WIDTH-1:0] mem [1:LAST_IX];

    // State register; reset restarts clearing from x1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            idx   <= ADDR_W'(1);
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Next-state: walk idx 1..31, then hold in READY until reset.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            ST_INIT: begin
                if (idx == ADDR_W'(LAST_IX)) begin
                    next_state = ST_READY;
                end else begin
                    next_idx = idx + ADDR_W'(1);
                end
            end
            ST_READY: begin
                next_state = ST_READY;
            end
            default: begin
                next_state = ST_INIT;
                next_idx   = ADDR_W'(1);
            end
        endcase
    end

    // Output decode: storage write enables and ready flag.
    // A write coinciding with reset is dropped, as is a clearing step.
    always_comb begin
        ready_c  = 1'b0;
        clr_we_c = 1'b0;
        wr_we_c  = 1'b0;
        case (state)
            ST_INIT: begin
                clr_we_c = ~rst;
            end
            ST_READY: begin
                ready_c = 1'b1;
                wr_we_c = ~rst && reg_write_en_w && (reg_write_addr_w != '0);
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase
    end

    assign rf_ready = ready_c;

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[idx] <= '0;
        end else if (wr_we_c) begin
            mem[reg_write_addr_w] <= reg_writedata_w;
        end
    end

    // Source port 1: zero for x0 or while clearing, else bypass or stored value.
    always_comb begin
        rs1_data_d = '0;
        if (ready_c && (rs1_addr_d != '0)) begin
            if (BYPASS_EN && reg_write_en_w && (reg_write_addr_w == rs1_addr_d)) begin
                rs1_data_d = reg_writedata_w;
            end else begin
                rs1_data_d = mem[rs1_addr_d];
            end
        end
    end

    // Source port 2: evaluated independently of port 1.
    always_comb begin
        rs2_data_d = '0;
        if (ready_c && (rs2_addr_d != '0)) begin
            if (BYPASS_EN && reg_write_en_w && (reg_write_addr_w == rs2_addr_d)) begin
                rs2_data_d = reg_writedata_w;
            end else begin
                rs2_data_d = mem[rs2_addr_d];
            end
        end
    end

    // Debug port always shows committed storage.
    always_comb begin
        dbg_data = '0;
        if (ready_c && (dbg_addr != '0)) begin
            dbg_data = mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_reg_file_bank.sv
module tb_reg_file_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        we;
    logic [4:0]  a1, a2, ad;
    logic [31:0] rs1_b, rs2_b, dbg_b, rs1_n, rs2_n, dbg_n;
    logic        rdy_b, rdy_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_bank #(.DATA_WIDTH(32), .BYPASS_EN(1'b1)) dut_byp (
        .clk(clk), .rst(rst),
        .reg_writedata_w(wd), .reg_write_addr_w(wa), .reg_write_en_w(we),
        .rs1_addr_d(a1), .rs2_addr_d(a2),
        .rs1_data_d(rs1_b), .rs2_data_d(rs2_b),
        .dbg_addr(ad), .dbg_data(dbg_b), .rf_ready(rdy_b)
    );

    reg_file_bank #(.DATA_WIDTH(32), .BYPASS_EN(1'b0)) dut_nobyp (
        .clk(clk), .rst(rst),
        .reg_writedata_w(wd), .reg_write_addr_w(wa), .reg_write_en_w(we),
        .rs1_addr_d(a1), .rs2_addr_d(a2),
        .rs1_data_d(rs1_n), .rs2_data_d(rs2_n),
        .dbg_addr(ad), .dbg_data(dbg_n), .rf_ready(rdy_n)
    );

    // Reference model: architectural register values plus number of clears done.
    logic [31:0] m [32];
    int          cleared;

    function automatic bit m_ready();
        return cleared >= 31;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (!m_ready() || a == 5'd0) return 32'd0;
        if (byp && we && wa == a) return wd;
        return m[a];
    endfunction

    function automatic logic [31:0] m_dbg(input logic [4:0] a);
        if (!m_ready() || a == 5'd0) return 32'd0;
        return m[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa_i,
                         input logic [31:0] wd_i, input logic [4:0] a1_i,
                         input logic [4:0] a2_i, input logic [4:0] ad_i);
        @(negedge clk);
        rst = r; we = w; wa = wa_i; wd = wd_i; a1 = a1_i; a2 = a2_i; ad = ad_i;
        #1;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            cleared = 0;
        end else if (cleared < 31) begin
            cleared++;
            m[cleared] = 32'd0;
        end else if (we && wa != 5'd0) begin
            m[wa] = wd;
        end
    endtask

    task automatic check_all();
        chk("rdy_byp",  32'(rdy_b), 32'(m_ready()));
        chk("rdy_nob",  32'(rdy_n), 32'(m_ready()));
        chk("rs1_byp",  rs1_b, m_rd(a1, 1'b1));
        chk("rs2_byp",  rs2_b, m_rd(a2, 1'b1));
        chk("rs1_nob",  rs1_n, m_rd(a1, 1'b0));
        chk("rs2_nob",  rs2_n, m_rd(a2, 1'b0));
        chk("dbg_byp",  dbg_b, m_dbg(ad));
        chk("dbg_nob",  dbg_n, m_dbg(ad));
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1, a2, ad;
        logic [31:0] e1b, e2b, e1n, e2n, ed;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n;
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[1] = '{1'b0, 5'd0, 32'd0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3] = '{1'b0, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[4] = '{1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[5] = '{1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'h1, 32'h1, 32'h1};
        tbl[6] = '{1'b0, 5'd0, 32'd0,        5'd7, 5'd5, 5'd7, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};

        cleared = 0;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0; ad = '0;

        // Reset, then clearing sequence with a write attempt to x3 at step 2.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        for (int k = 1; k <= 31; k++) begin
            if (k == 2) drive(1'b0, 1'b1, 5'd3, 32'h55, 5'(k), 5'd3, 5'(k));
            else        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(k), 5'd3, 5'(k));
            chk("init_not_ready", 32'(rdy_b), 32'd0);
            check_all();
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        chk("ready_after_31", 32'(rdy_b), 32'd1);

        // Every register reads zero after clearing, including x3.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 5'(i));
            chk("dbg_cleared", dbg_b, 32'd0);
            check_all();
            step();
        end

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2, tbl[i].ad);
            chk("vec_rs1_byp", rs1_b, tbl[i].e1b);
            chk("vec_rs2_byp", rs2_b, tbl[i].e2b);
            chk("vec_rs1_nob", rs1_n, tbl[i].e1n);
            chk("vec_rs2_nob", rs2_n, tbl[i].e2n);
            chk("vec_dbg",     dbg_b, tbl[i].ed);
            check_all();
            step();
        end

        // Write x10, reset, then re-reset at clearing step 15.
        drive(1'b0, 1'b1, 5'd10, 32'hAA, 5'd0, 5'd0, 5'd10);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 5'd10);
        chk("x10_written", dbg_b, 32'hAA);
        drive(1'b1, 1'b1, 5'd11, 32'h77, 5'd0, 5'd0, 5'd0);
        step();
        for (int k = 1; k < 15; k++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd10, 5'd10);
            check_all();
            step();
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        step();
        n = 0;
        while (n < 40) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11, 5'd10);
            if (rdy_b) break;
            step();
            n++;
        end
        chk("restart_edges", 32'(n), 32'd31);
        chk("x10_cleared", rs1_b, 32'd0);
        chk("x10_dbg_cleared", dbg_b, 32'd0);
        chk("x11_rst_write_dropped", rs2_b, 32'd0);
        check_all();
        step();

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 80) == 0, 1'($urandom), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom));
            if ($urandom % 4 == 0) begin
                a1 = wa;
                a2 = wa;
                #1;
            end
            check_all();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
